// File: rtl/ica_iteration_ctrl.sv
// ica_iteration_ctrl: FastICA sequencer driving init/update/orth/norm units and committing unmixing columns
module ica_iteration_ctrl #(
  parameter int SIZE_C = 3,
  parameter int N_BITS = 22,
  parameter int MAX_ITER = 64,
  parameter logic [N_BITS-1:0] CONV_LIMIT = 22'h3FFF00,
  localparam int CW = SIZE_C > 1 ? $clog2(SIZE_C) : 1,
  localparam int IW = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              init_start,
  input  logic              init_done,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              orth_start,
  input  logic              orth_done,
  output logic              norm_start,
  input  logic              norm_done,
  input  logic [N_BITS-1:0] conv_metric,
  output logic              wr_en,
  output logic [CW-1:0]     wr_col,
  output logic [CW-1:0]     comp_idx,
  output logic [IW-1:0]     iter_cnt,
  output logic              busy,
  output logic              done,
  output logic [SIZE_C-1:0] timeout_mask
);
  typedef enum logic [2:0] {IDLE, INIT, UPDATE, ORTH, NORM, CHECK, COMMIT, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(SIZE_C - 1);
  state_t state;
  logic [N_BITS-1:0] metric;
  logic [IW-1:0] iter_nxt;
  logic conv;
  assign iter_nxt = iter_cnt + IW'(1);
  assign conv = metric >= CONV_LIMIT;
  // Sequencer: each *_start is raised on entry and masks its *_done for that first cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      init_start <= 1'b0;
      upd_start <= 1'b0;
      orth_start <= 1'b0;
      norm_start <= 1'b0;
      wr_en <= 1'b0;
      wr_col <= '0;
      comp_idx <= '0;
      iter_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout_mask <= '0;
      metric <= '0;
    end else begin
      init_start <= 1'b0;
      upd_start <= 1'b0;
      orth_start <= 1'b0;
      norm_start <= 1'b0;
      wr_en <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state <= INIT;
            init_start <= 1'b1;
            comp_idx <= '0;
            iter_cnt <= '0;
            timeout_mask <= '0;
            busy <= 1'b1;
            done <= 1'b0;
          end
          INIT: if (init_done && !init_start) begin
            state <= UPDATE;
            upd_start <= 1'b1;
            iter_cnt <= '0;
          end
          UPDATE: if (upd_done && !upd_start) begin
            state <= comp_idx != '0 ? ORTH : NORM;
            orth_start <= comp_idx != '0;
            norm_start <= comp_idx == '0;
          end
          ORTH: if (orth_done && !orth_start) begin
            state <= NORM;
            norm_start <= 1'b1;
          end
          NORM: if (norm_done && !norm_start) begin
            state <= CHECK;
            metric <= conv_metric;
          end
          CHECK: begin
            iter_cnt <= iter_nxt;
            if (conv || iter_nxt == IW'(MAX_ITER)) begin
              state <= COMMIT;
              wr_en <= 1'b1;
              wr_col <= comp_idx;
              if (!conv) timeout_mask[comp_idx] <= 1'b1;
            end else begin
              state <= UPDATE;
              upd_start <= 1'b1;
            end
          end
          COMMIT: if (comp_idx == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= INIT;
            init_start <= 1'b1;
            comp_idx <= comp_idx + CW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ica_iteration_ctrl.sv
// tb_ica_iteration_ctrl: scoreboard bench with modelled math units for ica_iteration_ctrl
module tb_ica_iteration_ctrl;
  localparam logic [21:0] CL = 22'h3FFF00;
  typedef struct packed {logic [1:0] col; logic [2:0] iter; logic [2:0] mask;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic init_done = 0, upd_done = 0, orth_done = 0, norm_done = 0;
  logic [21:0] conv_metric = '0;
  logic init_start, upd_start, orth_start, norm_start, wr_en, busy, done;
  logic [1:0] wr_col, comp_idx;
  logic [2:0] iter_cnt, timeout_mask;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  bit auto_en = 1, p_init = 0, p_upd = 0, p_orth = 0, p_norm = 0;
  int mode = 0;
  logic [21:0] mval = '0;
  int upd_cnt[3], orth_cnt[3], run_len[5];

  ica_iteration_ctrl #(.SIZE_C(3), .N_BITS(22), .MAX_ITER(4), .CONV_LIMIT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .init_start(init_start), .init_done(init_done),
    .upd_start(upd_start), .upd_done(upd_done),
    .orth_start(orth_start), .orth_done(orth_done),
    .norm_start(norm_start), .norm_done(norm_done), .conv_metric(conv_metric),
    .wr_en(wr_en), .wr_col(wr_col), .comp_idx(comp_idx), .iter_cnt(iter_cnt),
    .busy(busy), .done(done), .timeout_mask(timeout_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sel(input int s);
    return s == 0 ? init_start : s == 1 ? upd_start : s == 2 ? orth_start : norm_start;
  endfunction

  function automatic logic [63:0] outs();
    return {init_start, upd_start, orth_start, norm_start, wr_en, busy, done,
            wr_col, comp_idx, iter_cnt, timeout_mask};
  endfunction

  task automatic wait_sig(input int s, input string nm);
    int k = 0;
    while (!sel(s) && k < 300) begin tick(); k++; end
    if (!sel(s)) check(nm, 0, 1);
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Zero-wait unit model: *_done one cycle after the matching *_start
  initial forever begin
    @(negedge clk);
    if (auto_en) begin
      init_done = p_init;
      upd_done = p_upd;
      orth_done = p_orth;
      norm_done = p_norm;
      conv_metric = (mode == 0 || iter_cnt == 3'd3) ? mval : '0;
      p_init = init_start;
      p_upd = upd_start;
      p_orth = orth_start;
      p_norm = norm_start;
    end
  end

  // Monitor: pops expected commits on wr_en, counts start pulses and their widths
  initial forever begin
    @(negedge clk);
    if (wr_en) begin
      if (sb.size() == 0) check("unexpected_wr_en", 1, 0);
      else begin
        e = sb.pop_front();
        check("wr_col", wr_col, e.col);
        check("commit_iter_cnt", iter_cnt, e.iter);
        check("commit_timeout_mask", timeout_mask, e.mask);
      end
    end
    if (upd_start) upd_cnt[int'(comp_idx)]++;
    if (orth_start) orth_cnt[int'(comp_idx)]++;
    for (int i = 0; i < 5; i++) begin
      if (i < 4 ? sel(i) : wr_en) run_len[i]++;
      else begin
        if (run_len[i] > 0) check($sformatf("pulse_width_%0d", i), run_len[i], 1);
        run_len[i] = 0;
      end
    end
  end

  task automatic run_full(input int m, input logic [21:0] v, input int it, input logic [2:0] fm);
    int k = 0;
    exp_t t;
    mode = m;
    mval = v;
    for (int i = 0; i < 3; i++) begin upd_cnt[i] = 0; orth_cnt[i] = 0; end
    for (int c = 0; c < 3; c++) begin
      t.col = 2'(c);
      t.iter = 3'(it);
      t.mask = fm & 3'((1 << (c + 1)) - 1);
      sb.push_back(t);
    end
    pulse_start();
    check("start_busy", busy, 1);
    check("start_done_low", done, 0);
    check("start_mask_clear", timeout_mask, 0);
    check("start_comp_idx", comp_idx, 0);
    while (!done && k < 2000) begin tick(); k++; end
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("final_timeout_mask", timeout_mask, fm);
    check("commits_outstanding", sb.size(), 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("upd_starts_comp%0d", c), upd_cnt[c], it);
      check($sformatf("orth_starts_comp%0d", c), orth_cnt[c], c > 0 ? it : 0);
    end
    tick(2);
  endtask

  initial begin
    tick(3);
    check("reset_outputs", outs(), 0);
    rst_n = 1;
    tick();
    check("post_reset_outputs", outs(), 0);
    mode = 0;
    mval = '0;
    pulse_start();
    wait_sig(3, "reach_norm");
    rst_n = 0;
    #1;
    check("async_reset_outputs", outs(), 0);
    tick(2);
    rst_n = 1;
    tick();
    check("release_outputs", outs(), 0);
    run_full(0, 22'h3FFFFF, 1, 3'b000);
    run_full(1, CL, 4, 3'b000);
    run_full(0, 22'h000000, 4, 3'b111);
    run_full(0, CL - 22'd1, 4, 3'b111);
    mode = 0;
    mval = 22'h3FFFFF;
    e.col = 2'd0; e.iter = 3'd1; e.mask = 3'd0;
    sb.push_back(e);
    pulse_start();
    check("abort_run_mask_clear", timeout_mask, 0);
    wait_sig(2, "reach_orth");
    check("orth_comp_idx", comp_idx, 1);
    abort = 1;
    start = 1;
    tick();
    abort = 0;
    start = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_comp_hold", comp_idx, 1);
    check("abort_iter_hold", iter_cnt, 0);
    tick(10);
    check("abort_commits", sb.size(), 0);
    check("abort_idle_busy", busy, 0);
    run_full(0, 22'h3FFFFF, 1, 3'b000);
    auto_en = 0;
    tick(2);
    {init_done, upd_done, orth_done, norm_done} = '0;
    e.col = 2'd0; e.iter = 3'd1; e.mask = 3'd0;
    sb.push_back(e);
    pulse_start();
    tick();
    init_done = 1;
    tick();
    init_done = 0;
    check("hs_upd_start", upd_start, 1);
    tick();
    conv_metric = 22'h3FFFFF;
    norm_done = 1;
    tick();
    norm_done = 0;
    tick(2);
    check("hs_stray_norm_done", {norm_start, orth_start, wr_en, busy}, 4'b0001);
    upd_done = 1;
    tick();
    upd_done = 0;
    check("hs_norm_start", norm_start, 1);
    tick();
    upd_done = 1;
    tick();
    upd_done = 0;
    tick(2);
    check("hs_stray_upd_done", {upd_start, norm_start, wr_en, busy}, 4'b0001);
    norm_done = 1;
    tick();
    norm_done = 0;
    tick(3);
    check("hs_commits", sb.size(), 0);
    check("hs_comp_idx", comp_idx, 1);
    abort = 1;
    tick();
    abort = 0;
    tick(2);
    check("end_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
